// File: rtl/ram_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_phase_sequencer_pkg
// Description : Shared phase and dump-reader state encodings for the RAM
//               phase sequencer, its status decode and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_phase_sequencer_pkg;

    // Externally visible phase, also the top-level FSM state
    localparam int         PHASE_W = 2;
    localparam logic [1:0] PH_LOAD = 2'd0;
    localparam logic [1:0] PH_RUN  = 2'd1;
    localparam logic [1:0] PH_DUMP = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    // Dump reader FSM states
    localparam int         RD_STATE_W = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRD     = 3'd1;
    localparam logic [2:0] ST_DWAIT   = 3'd2;
    localparam logic [2:0] ST_DTXL    = 3'd3;
    localparam logic [2:0] ST_DTXH    = 3'd4;

endpackage : ram_phase_sequencer_pkg
`default_nettype wire

// File: rtl/ram_phase_sequencer_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_phase_sequencer_dump_reader
// Description : Walks DUMP_LEN RAM words from DUMP_BASE (address wraps at
//               2^AW), registers each word and serialises it low byte first
//               onto a valid/ready byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_phase_sequencer_dump_reader
    import ram_phase_sequencer_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_ramRdata,
    output logic [AW-1:0] o_ramAddr,
    output logic          o_txValid,
    output logic [7:0]    o_txData,
    input  logic          i_txReady,
    output logic          o_finished
);

    localparam logic [AW-1:0] c_base    = AW'(DUMP_BASE);
    localparam logic [AW-1:0] c_lastCnt = AW'(DUMP_LEN - 1);

    logic [RD_STATE_W-1:0] r_state;
    logic [AW-1:0]         r_cnt;
    logic [DW-1:0]         r_hold;
    logic [7:0]            w_hiByte;
    logic                  w_lastWord;

    // Upper byte of the held word, zero-padded for narrow RAMs
    if (DW >= 16) begin : g_hiFull
        assign w_hiByte = r_hold[15:8];
    end else if (DW > 8) begin : g_hiPad
        assign w_hiByte = {{(16 - DW){1'b0}}, r_hold[DW-1:8]};
    end else begin : g_hiNone
        assign w_hiByte = 8'h00;
    end

    assign w_lastWord = (r_cnt == c_lastCnt);

    // Address generation and byte serialiser decode from the registered state
    assign o_ramAddr  = c_base + r_cnt;
    assign o_txValid  = (r_state == ST_DTXL) || (r_state == ST_DTXH);
    assign o_txData   = (r_state == ST_DTXH) ? w_hiByte : r_hold[7:0];
    assign o_finished = (r_state == ST_DTXH) && i_txReady && w_lastWord;

    // Read-issue / capture / low-byte / high-byte sequence, one word at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRD;
                    end
                end
                ST_DRD: begin
                    r_state <= ST_DWAIT;
                end
                ST_DWAIT: begin
                    // RAM read data lands one cycle after the address
                    r_hold  <= i_ramRdata;
                    r_state <= ST_DTXL;
                end
                ST_DTXL: begin
                    if (i_txReady) begin
                        r_state <= ST_DTXH;
                    end
                end
                ST_DTXH: begin
                    if (i_txReady) begin
                        if (w_lastWord) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + AW'(1);
                            r_state <= ST_DRD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ram_phase_sequencer_dump_reader
`default_nettype wire

// File: rtl/ram_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_phase_sequencer
// Description : Owns the single-port data RAM and sequences its users:
//               UART load, CPU execution, then UART result dump.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_phase_sequencer
    import ram_phase_sequencer_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_wr_valid,
    input  logic [AW-1:0] uart_wr_addr,
    input  logic [DW-1:0] uart_wr_data,
    input  logic          uart_load_done,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_end_ops,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_run,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    phase,
    output logic          dump_done
);

    localparam logic c_emptyDump = (DUMP_LEN == 0);

    logic [PHASE_W-1:0] r_phase;
    logic               r_cpuRun;
    logic               r_dumpDone;
    logic               w_dumpStart;
    logic               w_dumpFinished;
    logic [AW-1:0]      w_dumpAddr;
    logic               w_txValid;
    logic [7:0]         w_txData;

    assign phase     = r_phase;
    assign cpu_run   = r_cpuRun;
    assign dump_done = r_dumpDone;
    assign cpu_rdata = ram_rdata;

    // The reader only presents bytes while the dump phase is active
    assign tx_valid  = w_txValid && (r_phase == PH_DUMP);
    assign tx_data   = w_txData;

    assign w_dumpStart = (r_phase == PH_RUN) && cpu_end_ops && !c_emptyDump;

    ram_phase_sequencer_dump_reader #(
        .AW        (AW),
        .DW        (DW),
        .DUMP_BASE (DUMP_BASE),
        .DUMP_LEN  (DUMP_LEN)
    ) u_dumpReader (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_dumpStart),
        .i_ramRdata (ram_rdata),
        .o_ramAddr  (w_dumpAddr),
        .o_txValid  (w_txValid),
        .o_txData   (w_txData),
        .i_txReady  (tx_ready),
        .o_finished (w_dumpFinished)
    );

    // Phase FSM with registered run-enable and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_LOAD;
            r_cpuRun   <= 1'b0;
            r_dumpDone <= 1'b0;
        end else begin
            case (r_phase)
                PH_LOAD: begin
                    if (uart_load_done) begin
                        r_phase  <= PH_RUN;
                        r_cpuRun <= 1'b1;
                    end
                end
                PH_RUN: begin
                    if (cpu_end_ops) begin
                        r_cpuRun <= 1'b0;
                        if (c_emptyDump) begin
                            r_phase    <= PH_DONE;
                            r_dumpDone <= 1'b1;
                        end else begin
                            r_phase <= PH_DUMP;
                        end
                    end
                end
                PH_DUMP: begin
                    if (w_dumpFinished) begin
                        r_phase    <= PH_DONE;
                        r_dumpDone <= 1'b1;
                    end
                end
                default: begin
                    r_phase <= PH_DONE;
                end
            endcase
        end
    end

    // RAM port mux: only the loader and the CPU may ever write
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (r_phase)
            PH_LOAD: begin
                ram_addr  = uart_wr_addr;
                ram_wdata = uart_wr_data;
                ram_we    = uart_wr_valid;
            end
            PH_RUN: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
            end
            PH_DUMP: begin
                ram_addr  = w_dumpAddr;
            end
            default: begin
                ram_addr  = '0;
            end
        endcase
    end

endmodule : ram_phase_sequencer
`default_nettype wire

// File: tb/tb_ram_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_phase_sequencer
// Description : Scoreboard bench. Three sequencers share stimulus:
//               A (base 0, 3 words), W (base 0xFFFE, 4 words, wraps) and
//               E (empty dump). Each has its own RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_phase_sequencer;
    import ram_phase_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_wr_valid, uart_load_done, cpu_we, cpu_end_ops, tx_ready;
    logic [15:0] uart_wr_addr, uart_wr_data, cpu_addr, cpu_wdata;

    logic [15:0] rdA, rdW, rdE, crdA, crdW, crdE, addrA, addrW, addrE;
    logic [15:0] wdA, wdW, wdE;
    logic        weA, weW, weE, runA, runW, runE, tvA, tvW, tvE, ddA, ddW, ddE;
    logic [7:0]  tdA, tdW, tdE;
    logic [1:0]  phA, phW, phE;

    logic [15:0] memA [0:65535];
    logic [15:0] memW [0:65535];
    logic [15:0] memE [0:65535];

    logic [7:0]  expA[$];
    logic [7:0]  expW[$];
    logic [7:0]  popA, popW;
    int          total = 0;
    int          bad   = 0;
    int          hsA   = 0;
    int          txCntE = 0;

    always #5 clk = ~clk;

    ram_phase_sequencer #(.AW(16), .DW(16), .DUMP_BASE(0), .DUMP_LEN(3)) dutA (
        .clk(clk), .rst(rst), .uart_wr_valid(uart_wr_valid), .uart_wr_addr(uart_wr_addr),
        .uart_wr_data(uart_wr_data), .uart_load_done(uart_load_done), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_end_ops(cpu_end_ops), .cpu_rdata(crdA),
        .cpu_run(runA), .tx_valid(tvA), .tx_data(tdA), .tx_ready(tx_ready), .ram_addr(addrA),
        .ram_wdata(wdA), .ram_we(weA), .ram_rdata(rdA), .phase(phA), .dump_done(ddA));

    ram_phase_sequencer #(.AW(16), .DW(16), .DUMP_BASE(16'hFFFE), .DUMP_LEN(4)) dutW (
        .clk(clk), .rst(rst), .uart_wr_valid(uart_wr_valid), .uart_wr_addr(uart_wr_addr),
        .uart_wr_data(uart_wr_data), .uart_load_done(uart_load_done), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_end_ops(cpu_end_ops), .cpu_rdata(crdW),
        .cpu_run(runW), .tx_valid(tvW), .tx_data(tdW), .tx_ready(tx_ready), .ram_addr(addrW),
        .ram_wdata(wdW), .ram_we(weW), .ram_rdata(rdW), .phase(phW), .dump_done(ddW));

    ram_phase_sequencer #(.AW(16), .DW(16), .DUMP_BASE(0), .DUMP_LEN(0)) dutE (
        .clk(clk), .rst(rst), .uart_wr_valid(uart_wr_valid), .uart_wr_addr(uart_wr_addr),
        .uart_wr_data(uart_wr_data), .uart_load_done(uart_load_done), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_end_ops(cpu_end_ops), .cpu_rdata(crdE),
        .cpu_run(runE), .tx_valid(tvE), .tx_data(tdE), .tx_ready(tx_ready), .ram_addr(addrE),
        .ram_wdata(wdE), .ram_we(weE), .ram_rdata(rdE), .phase(phE), .dump_done(ddE));

    // Single-port RAM models: read-before-write, one-cycle registered read
    always @(posedge clk) begin
        if (weA) memA[addrA] <= wdA;
        if (weW) memW[addrW] <= wdW;
        if (weE) memE[addrE] <= wdE;
        rdA <= memA[addrA];
        rdW <= memW[addrW];
        rdE <= memE[addrE];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted byte is popped from its scoreboard queue
    always @(negedge clk) begin
        if (!rst) begin
            if (tvA && tx_ready) begin
                hsA++;
                if (expA.size() == 0) begin
                    chk("txA unexpected byte", {24'h0, tdA}, 32'h100);
                end else begin
                    popA = expA.pop_front();
                    chk("txA byte", {24'h0, tdA}, {24'h0, popA});
                end
            end
            if (tvW && tx_ready) begin
                if (expW.size() == 0) begin
                    chk("txW unexpected byte", {24'h0, tdW}, 32'h100);
                end else begin
                    popW = expW.pop_front();
                    chk("txW byte", {24'h0, tdW}, {24'h0, popW});
                end
            end
            if (tvE) txCntE++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFull();
        logic [7:0] a [6];
        logic [7:0] w [8];
        a = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
        w = '{8'h01, 8'h5A, 8'h02, 8'h6B, 8'h34, 8'h12, 8'hCD, 8'hAB};
        foreach (a[i]) expA.push_back(a[i]);
        foreach (w[i]) expW.push_back(w[i]);
    endtask

    task automatic waitDone(input string nm);
        int n;
        n = 0;
        while (!(ddA && ddW) && n < 200) begin
            step();
            n++;
        end
        chk({nm, " done within budget"}, {31'h0, ddA && ddW}, 32'h1);
    endtask

    initial begin
        logic [15:0] cAddr [5];
        logic [15:0] cData [5];
        int          n;
        int          hsBase;
        cAddr = '{16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0002};
        cData = '{16'h1234, 16'hABCD, 16'h5A01, 16'h6B02, 16'h00FF};

        rst = 1'b1; uart_wr_valid = 1'b0; uart_load_done = 1'b0; cpu_we = 1'b0;
        cpu_end_ops = 1'b0; tx_ready = 1'b0; uart_wr_addr = '0; uart_wr_data = '0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) step();
        chk("reset phase", phA, PH_LOAD);
        chk("reset cpu_run", runA, 0);
        chk("reset tx_valid", tvA, 0);
        chk("reset dump_done", ddA, 0);
        chk("reset ram_we", weA, 0);
        rst = 1'b0;

        // Load four words, load_done on the last write
        for (int i = 0; i < 4; i++) begin
            uart_wr_valid  = 1'b1;
            uart_wr_addr   = 16'(i);
            uart_wr_data   = 16'h1111 * 16'(i + 1);
            uart_load_done = (i == 3);
            step();
        end
        uart_wr_valid = 1'b0; uart_load_done = 1'b0;
        chk("phase after load", phA, PH_RUN);
        chk("cpu_run after load", runA, 1);
        for (int i = 0; i < 4; i++) chk("loaded word", memA[i], 16'h1111 * 16'(i + 1));

        // CPU write wins over a simultaneous loader write
        cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hBEEF;
        uart_wr_valid = 1'b1; uart_wr_addr = 16'h0005; uart_wr_data = 16'h0000;
        step();
        uart_wr_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0003;
        step();
        chk("RAM[5] cpu write", memA[5], 16'hBEEF);
        chk("cpu_rdata RAM[3]", crdA, 16'h4444);

        // CPU fills dump area; last write coincides with end_ops
        for (int i = 0; i < 5; i++) begin
            cpu_we = 1'b1; cpu_addr = cAddr[i]; cpu_wdata = cData[i];
            cpu_end_ops = (i == 4);
            step();
        end
        cpu_we = 1'b0; cpu_end_ops = 1'b0;
        chk("cpu_run drops", runA, 0);
        chk("phase dump", phA, PH_DUMP);
        chk("empty dump phase", phE, PH_DONE);
        chk("empty dump_done", ddE, 1);
        chk("RAM[2] end-cycle write", memA[2], 16'h00FF);
        pushFull();

        // Stall in DTXL: byte and address must hold
        n = 0;
        while (!tvA && n < 20) begin step(); n++; end
        chk("tx_valid reached", tvA, 1);
        for (int k = 0; k < 10; k++) begin
            chk("stall tx_valid", tvA, 1);
            chk("stall tx_data A", tdA, 8'h34);
            chk("stall addr A", addrA, 16'h0000);
            chk("stall tx_data W", tdW, 8'h01);
            chk("stall addr W", addrW, 16'hFFFE);
            step();
        end
        tx_ready = 1'b1;
        waitDone("first dump");
        chk("phase A done", phA, PH_DONE);
        chk("phase W done", phW, PH_DONE);
        chk("queue A drained", expA.size(), 0);
        chk("queue W drained", expW.size(), 0);
        chk("done tx_valid", tvA, 0);

        // Second pass aborted by reset during word 1 high byte
        rst = 1'b1; step(); rst = 1'b0;
        uart_load_done = 1'b1; step(); uart_load_done = 1'b0;
        chk("reload phase", phA, PH_RUN);
        hsBase = hsA;
        expA.push_back(8'h34); expA.push_back(8'h12); expA.push_back(8'hCD);
        expW.push_back(8'h01); expW.push_back(8'h5A); expW.push_back(8'h02);
        cpu_end_ops = 1'b1; step(); cpu_end_ops = 1'b0;
        n = 0;
        while ((hsA - hsBase) < 3 && n < 50) begin step(); n++; end
        chk("DTXH word1 reached", hsA - hsBase, 3);
        chk("DTXH word1 byte", tdA, 8'hAB);
        rst = 1'b1; tx_ready = 1'b0;
        step();
        chk("abort phase", phA, PH_LOAD);
        chk("abort tx_valid", tvA, 0);
        chk("abort cpu_run", runA, 0);
        chk("abort dump_done", ddA, 0);
        chk("abort queue A", expA.size(), 0);
        chk("abort queue W", expW.size(), 0);
        chk("abort phase E", phE, PH_LOAD);
        rst = 1'b0;

        // Full restart: dump must begin again from word 0
        uart_load_done = 1'b1; step(); uart_load_done = 1'b0;
        pushFull();
        tx_ready = 1'b1; cpu_end_ops = 1'b1; step(); cpu_end_ops = 1'b0;
        chk("restart empty dump_done", ddE, 1);
        waitDone("restart dump");
        chk("restart queue A", expA.size(), 0);
        chk("restart queue W", expW.size(), 0);
        chk("restart phase W", phW, PH_DONE);
        chk("empty dump never valid", txCntE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_ram_phase_sequencer
`default_nettype wire
